// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core with 16-bit encoding, DATA_W-wide datapath and one shared req/ready memory port.
// Optional macro MIPS_MC_TRAP_EN: an illegal R-type funct halts the core with a sticky trap.
module mips_multicycle_core #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              retire,
  output logic              trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef MIPS_MC_TRAP_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;
  localparam logic [DATA_W-1:0] PcStep = DATA_W'(2);

  state_t            r_state, w_next_state;
  logic [DATA_W-1:0] r_pc, r_a, r_b, r_mdr, r_alu;
  logic [15:0]       r_ir;
  logic              r_retire;
  logic [DATA_W-1:0] r_regs [8];

  logic [2:0]        w_op, w_rs, w_rt, w_rd, w_rf_waddr;
  logic [3:0]        w_funct;
  logic [DATA_W-1:0] w_imm, w_imm_sh, w_jtarget, w_alu, w_rf_wdata;
  logic              w_is_jr, w_illegal, w_retire_next, w_rf_we;

  assign w_op      = r_ir[15:13];
  assign w_rs      = r_ir[12:10];
  assign w_rt      = r_ir[9:7];
  assign w_rd      = r_ir[6:4];
  assign w_funct   = r_ir[3:0];
  assign w_imm     = {{(DATA_W-7){r_ir[6]}}, r_ir[6:0]};
  assign w_imm_sh  = {{(DATA_W-8){r_ir[6]}}, r_ir[6:0], 1'b0};
  // r_pc already holds pc+2 once the fetch has completed
  assign w_jtarget = {r_pc[DATA_W-1:14], r_ir[12:0], 1'b0};
  assign w_is_jr   = (w_op == OP_R) && (w_funct == 4'd8);
  assign w_illegal = (w_op == OP_R) && (w_funct > 4'd4) && (w_funct != 4'd8);

  assign pc_out     = r_pc;
  assign alu_result = r_alu;
  assign retire     = r_retire;

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_R: begin
        case (w_funct)
          4'd0:    w_alu = r_a + r_b;
          4'd1:    w_alu = r_a - r_b;
          4'd2:    w_alu = r_a & r_b;
          4'd3:    w_alu = r_a | r_b;
          4'd4:    w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
          4'd8:    w_alu = r_a;
          default: w_alu = '0;
        endcase
      end
      OP_SLTI:                    w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_imm))};
      OP_LW, OP_SW, OP_ADDI:      w_alu = r_a + w_imm;
      OP_BEQ:                     w_alu = r_a - r_b;
      default:                    w_alu = '0;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    w_retire_next = 1'b0;
    case (r_state)
      S_FETCH: if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_J || w_op == OP_JAL) begin
          w_next_state  = S_FETCH;
          w_retire_next = 1'b1;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_op == OP_BEQ || w_is_jr) begin
          w_next_state  = S_FETCH;
          w_retire_next = 1'b1;
        end else if (w_op == OP_LW || w_op == OP_SW) begin
          w_next_state = S_MEM;
        end else if (w_illegal) begin
`ifdef MIPS_MC_TRAP_EN
          w_next_state  = S_HALT;
`else
          w_next_state  = S_FETCH;
          w_retire_next = 1'b1;
`endif
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          w_next_state  = (w_op == OP_LW) ? S_WB : S_FETCH;
          w_retire_next = (w_op != OP_LW);
        end
      end
      S_WB: begin
        w_next_state  = S_FETCH;
        w_retire_next = 1'b1;
      end
      default: w_next_state = r_state;
    endcase
  end

  // Memory outputs follow the state directly so reset removes a pending request at once
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (r_state == S_FETCH) begin
        mem_req  = 1'b1;
        mem_addr = r_pc;
      end else if (r_state == S_MEM) begin
        mem_req   = 1'b1;
        mem_we    = (w_op == OP_SW);
        mem_addr  = r_alu;
        mem_wdata = r_b;
      end
    end
  end

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = 3'd0;
    w_rf_wdata = '0;
    if (r_state == S_DECODE && w_op == OP_JAL) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = 3'd7;
      w_rf_wdata = r_pc;
    end else if (r_state == S_WB) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = (w_op == OP_R) ? w_rd : w_rt;
      w_rf_wdata = (w_op == OP_LW) ? r_mdr : r_alu;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (w_rf_we && w_rf_waddr != 3'd0) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mdr    <= '0;
      r_alu    <= '0;
      r_retire <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_retire <= w_retire_next;
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir <= mem_rdata[15:0];
            r_pc <= r_pc + PcStep;
          end
        end
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
          if (w_op == OP_J || w_op == OP_JAL) r_pc <= w_jtarget;
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_op == OP_BEQ && r_a == r_b) r_pc <= r_pc + w_imm_sh;
          else if (w_is_jr)                 r_pc <= r_a;
`ifdef MIPS_MC_TRAP_EN
          else if (w_illegal)               r_pc <= r_pc - PcStep;
`endif
        end
        S_MEM: if (mem_ready && w_op == OP_LW) r_mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

`ifdef MIPS_MC_TRAP_EN
  logic r_trap;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_trap <= 1'b0;
    else if (r_state == S_EXEC && w_illegal)     r_trap <= 1'b1;
  end
  assign trap = r_trap;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Testbench for mips_multicycle_core: a memory responder with programmable wait states checks every
// memory transaction against a queue of expected fetches/loads/stores; retire spacing is checked per instruction.
module tb_mips_multicycle_core;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, retire, trap;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out, alu_result;

  int   checks = 0;
  int   failures = 0;
  int   waitCycles = 0;
  txn_t expQ[$];
  logic [15:0] mem [0:255];

  mips_multicycle_core #(.DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .alu_result(alu_result), .retire(retire), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  function automatic logic [15:0] encI(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt, input int imm);
    return {op, rs, rt, 7'(imm)};
  endfunction

  function automatic logic [15:0] encR(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd, input logic [3:0] funct);
    return {3'b000, rs, rt, rd, funct};
  endfunction

  function automatic logic [15:0] encJ(input logic [2:0] op, input int jidx);
    return {op, 13'(jidx)};
  endfunction

  task automatic pushTxn(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    expQ.push_back(t);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem['h00 >> 1] = encI(3'd7, 3'd0, 3'd1, 5);
    mem['h02 >> 1] = encI(3'd7, 3'd0, 3'd2, -3);
    mem['h04 >> 1] = encR(3'd1, 3'd2, 3'd3, 4'd0);
    mem['h06 >> 1] = encI(3'd5, 3'd0, 3'd3, 4);
    mem['h08 >> 1] = encI(3'd4, 3'd0, 3'd4, 4);
    mem['h0A >> 1] = encI(3'd5, 3'd0, 3'd4, 6);
    mem['h0C >> 1] = encJ(3'd2, 'h08);
    mem['h0E >> 1] = encJ(3'd2, 'h10);
    mem['h10 >> 1] = encI(3'd6, 3'd1, 3'd1, -2);
    mem['h20 >> 1] = encJ(3'd3, 'h40);
    mem['h22 >> 1] = encI(3'd1, 3'd2, 3'd5, 0);
    mem['h24 >> 1] = encI(3'd5, 3'd0, 3'd5, 12);
    mem['h26 >> 1] = encI(3'd5, 3'd0, 3'd7, 14);
    mem['h28 >> 1] = encI(3'd7, 3'd0, 3'd0, 7);
    mem['h2A >> 1] = encI(3'd5, 3'd0, 3'd0, 16);
    mem['h2C >> 1] = encI(3'd7, 3'd0, 3'd6, 9);
    mem['h2E >> 1] = encR(3'd5, 3'd1, 3'd5, 4'd3);
    mem['h30 >> 1] = encR(3'd1, 3'd2, 3'd6, 4'hF);
    mem['h32 >> 1] = encI(3'd5, 3'd0, 3'd6, 18);
    mem['h34 >> 1] = encR(3'd2, 3'd1, 3'd6, 4'd1);
    mem['h36 >> 1] = encI(3'd5, 3'd0, 3'd6, 20);
    mem['h38 >> 1] = encI(3'd5, 3'd0, 3'd5, 22);
    mem['h3A >> 1] = encJ(3'd2, 'h1D);
    mem['h80 >> 1] = encR(3'd7, 3'd0, 3'd0, 4'd8);

    // Expected memory traffic in program order: fetches, loads and stores
    pushTxn(0, 16'h00, 0); pushTxn(0, 16'h02, 0); pushTxn(0, 16'h04, 0);
    pushTxn(0, 16'h06, 0); pushTxn(1, 16'h04, 16'h0002);
    pushTxn(0, 16'h08, 0); pushTxn(0, 16'h04, 0);
    pushTxn(0, 16'h0A, 0); pushTxn(1, 16'h06, 16'h0002);
    pushTxn(0, 16'h0C, 0); pushTxn(0, 16'h10, 0); pushTxn(0, 16'h0E, 0);
    pushTxn(0, 16'h20, 0); pushTxn(0, 16'h80, 0); pushTxn(0, 16'h22, 0);
    pushTxn(0, 16'h24, 0); pushTxn(1, 16'h0C, 16'h0001);
    pushTxn(0, 16'h26, 0); pushTxn(1, 16'h0E, 16'h0022);
    pushTxn(0, 16'h28, 0); pushTxn(0, 16'h2A, 0); pushTxn(1, 16'h10, 16'h0000);
    pushTxn(0, 16'h2C, 0); pushTxn(0, 16'h2E, 0); pushTxn(0, 16'h30, 0);
`ifndef MIPS_MC_TRAP_EN
    pushTxn(0, 16'h32, 0); pushTxn(1, 16'h12, 16'h0009);
    pushTxn(0, 16'h34, 0); pushTxn(0, 16'h36, 0); pushTxn(1, 16'h14, 16'hFFF8);
    pushTxn(0, 16'h38, 0); pushTxn(1, 16'h16, 16'h0005);
    pushTxn(0, 16'h3A, 0);
`endif
  endtask

  task automatic waitRetire(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!retire && cyc < 40);
    checkOutput("retire_seen", retire, 1'b1);
  endtask

  // Memory model: decides mem_ready on the falling edge, so the core samples it on the next rising edge
  initial begin : responder
    int          waitCnt;
    logic        holdWe;
    logic [15:0] holdAddr, holdWdata;
    txn_t        t;
    waitCnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset || !mem_req) begin
        mem_ready = 1'b0;
        waitCnt = 0;
      end else if (waitCnt >= waitCycles) begin
        if (waitCnt > 0) checkOutput("req_stable", {mem_we, mem_addr, mem_wdata}, {holdWe, holdAddr, holdWdata});
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[8:1]];
        if (expQ.size() > 0) begin
          t = expQ.pop_front();
          checkOutput("txn_we", mem_we, t.we);
          checkOutput("txn_addr", mem_addr, t.addr);
          if (t.we) checkOutput("txn_wdata", mem_wdata, t.wdata);
        end
        if (mem_we) mem[mem_addr[8:1]] = mem_wdata;
        waitCnt = 0;
      end else begin
        if (waitCnt == 0) begin
          holdWe = mem_we; holdAddr = mem_addr; holdWdata = mem_wdata;
        end else begin
          checkOutput("req_stable", {mem_we, mem_addr, mem_wdata}, {holdWe, holdAddr, holdWdata});
        end
        mem_ready = 1'b0;
        waitCnt++;
      end
    end
  end

  initial begin : mainSeq
    int cyc;
    int expLat[23] = '{4, 4, 4, 10, 11, 4, 2, 3, 2, 2, 3, 4, 4, 4, 4, 4, 4, 4, 3, 4, 4, 4, 4};
    int nRetire;
    reset = 1'b1;
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_pc", pc_out, 16'h0000);
    checkOutput("rst_alu", alu_result, 16'h0000);
    checkOutput("rst_retire", retire, 1'b0);
    checkOutput("rst_trap", trap, 1'b0);

    // Stalled fetch interrupted by an asynchronous reset
    waitCycles = 50;
    @(posedge clk); #3; reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("stall_fetch_req", mem_req, 1'b1);
    checkOutput("stall_fetch_addr", mem_addr, 16'h0000);
    @(posedge clk); #3; reset = 1'b1; #1;
    checkOutput("async_req_drop", mem_req, 1'b0);
    checkOutput("async_pc", pc_out, 16'h0000);
    waitCycles = 0;
    @(posedge clk); #3; reset = 1'b0; #1;
    checkOutput("release_pc", pc_out, 16'h0000);
    checkOutput("release_retire", retire, 1'b0);

`ifdef MIPS_MC_TRAP_EN
    nRetire = 18;
`else
    nRetire = 23;
`endif
    for (int i = 0; i < nRetire; i++) begin
      waitRetire(cyc);
      checkOutput($sformatf("latency_%0d", i), cyc, expLat[i]);
      if (i == 2)  begin checkOutput("alu_add", alu_result, 16'h0002); waitCycles = 3; end
      if (i == 4)  waitCycles = 0;
      if (i == 11) checkOutput("alu_slti", alu_result, 16'h0001);
      if (i == 14) checkOutput("alu_addi_r0", alu_result, 16'h0007);
      if (i == 17) checkOutput("alu_or", alu_result, 16'h0005);
      if (i == 20) checkOutput("alu_sub", alu_result, 16'hFFF8);
    end

`ifdef MIPS_MC_TRAP_EN
    repeat (4) @(posedge clk);
    #1;
    checkOutput("trap_set", trap, 1'b1);
    checkOutput("trap_pc", pc_out, 16'h0030);
    checkOutput("trap_no_req", mem_req, 1'b0);
    checkOutput("trap_no_retire", retire, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("trap_sticky", trap, 1'b1);
    checkOutput("trap_still_no_req", mem_req, 1'b0);
`else
    repeat (3) @(posedge clk);
    #1;
    checkOutput("nop_trap_low", trap, 1'b0);
`endif
    checkOutput("sb_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor to the 16-bit single-cycle MIPS core; same 16-bit instruction encoding, datapath width set by DATA_W.
- Instruction fetch and data access share one memory port with a variable-latency req/ready handshake, so memory no longer has to be combinational.
- Sits between the top level and a unified instruction/data memory or bus adapter.

Parameters:
- DATA_W, 16, datapath, register, PC and address width; legal values are 16 or more.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  byte address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load/fetch data; instruction is mem_rdata[15:0].
- mem_ready  in  1  request accepted/completed this cycle.
- pc_out  out  DATA_W  current PC.
- alu_result  out  DATA_W  last registered ALU output.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  illegal-instruction halt (only with MIPS_MC_TRAP_EN; otherwise tied 0).

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high on port `reset`, clock port `clk`.
- Reset values: pc = RESET_PC; all 8 registers = 0; FSM = FETCH; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; alu_result = 0; retire = 0; trap = 0.
- Reset mid-transaction drops mem_req immediately; there is no completion.
- Encoding:
  - opcode [15:13], rs [12:10], rt [9:7], rd [6:4], funct [3:0], imm7 [6:0], jidx [12:0].
  - Opcodes: 000 R-type; 001 slti; 010 j; 011 jal; 100 lw; 101 sw; 110 beq; 111 addi.
  - R-type funct: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed), 8 jr. Any other funct is illegal.
- Arithmetic/width rules:
  - imm = sign-extend imm7 to DATA_W.
  - pc2 = pc + 2.
  - beq target = pc2 + (imm << 1).
  - j/jal target = {pc2[DATA_W-1:14], jidx, 1'b0}.
  - jal writes pc2 to r7.
  - All addition wraps modulo 2^DATA_W; slt/slti results are 1 or 0.
- Register file:
  - 8 x DATA_W; r0 reads 0 and writes to it are discarded.
  - R-type writes rd; addi/slti/lw write rt.
- FSM:
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. On mem_ready, latch IR and pc <= pc2 → DECODE. Without mem_ready, stay and hold all outputs stable.
  - DECODE: read rs/rt into A/B.
    - j/jal: set pc to the jump target (jal writes r7), pulse retire → FETCH.
    - Otherwise → EXEC.
  - EXEC: ALU operation, registered into alu_result.
    - beq: if A == B, pc <= beq target; pulse retire → FETCH.
    - jr: pc <= A; pulse retire → FETCH.
    - lw/sw (address = A + imm) → MEM.
    - Others → WB.
  - MEM: mem_req = 1, mem_addr = alu_result, mem_we = (sw), mem_wdata = B. Hold until mem_ready.
    - lw: latch mem_rdata into MDR → WB.
    - sw: pulse retire → FETCH.
  - WB: write ALU result or MDR; pulse retire → FETCH.
- Latency with zero-wait memory (mem_ready high in the request cycle): j/jal 2 cycles, beq/jr 3, R/addi/slti/sw 4, lw 5. Each wait cycle adds 1.
- Illegal funct without the optional feature: treated as a NOP. No register write, retire pulses at the end of EXEC.
- retire is registered and high for exactly one cycle per instruction.

Optional Feature:
- Macro: MIPS_MC_TRAP_EN.
- Defined: an illegal funct in EXEC enters a HALT state.
  - trap = 1 (sticky), pc_out = address of the offending instruction, mem_req = 0, no retire.
  - Only reset leaves HALT.
- Undefined: HALT state absent, trap tied 0, illegal funct behaves as a NOP as above.

Test Plan:
- Reset: assert reset asynchronously mid-FETCH with mem_req = 1 → mem_req drops the same cycle; pc_out = RESET_PC and retire = 0 after release.
- Arithmetic (DATA_W = 16): addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 → r3 = 2, alu_result = 0x0002; each retire spaced 4 cycles with zero-wait memory.
- Load/store with waits: mem_ready delayed 3 cycles per request; sw r3,4(r0) then lw r4,4(r0) → write at addr 4 with data 2; r4 = 2. Request signals stay stable while waiting; lw takes 5 + 6 wait cycles.
- Control flow:
  - beq r1,r1,-2 at 0x0010 → next fetch at 0x000E.
  - jal 0x0040 at 0x0020 → r7 = 0x0022, next fetch at 0x0080.
  - jr r7 → fetch 0x0022.
- Width and r0: DATA_W = 32: addi r1,r0,-1 then add r2,r1,r1 → r2 = 0xFFFFFFFE; addi r0,r0,7 → r0 still reads 0.
- Illegal funct: R-type funct 0xF at 0x0030.
  - Without MIPS_MC_TRAP_EN: retire pulses, no register changes.
  - With it: trap = 1, pc_out = 0x0030, no further mem_req until reset.
